// File: rtl/iq_capture_pkg.sv
// Shared definitions for the I/Q capture buffer: mode encodings, FSM states
// and the saturating magnitude helper.
package iq_capture_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_CIRC    = 2'd1;
  localparam logic [1:0] MODE_SKIP    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_CAPTURE,
    ST_DONE
  } cap_state_t;

  // |x| for a w-bit two's complement value held sign-extended in 32 bits;
  // the most negative value folds onto the largest positive one.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int w);
    logic signed [31:0] lo;
    lo = -(32'sd1 <<< (w - 1));
    if (x == lo)
      sat_abs = (32'd1 << (w - 1)) - 32'd1;
    else if (x < 0)
      sat_abs = 32'(-x);
    else
      sat_abs = 32'(x);
  endfunction

endpackage

// File: rtl/iq_capture_ram.sv
// Simple dual-port sample RAM with registered read; a same-address
// read/write collision returns the previously stored word.
module iq_capture_ram #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/iq_capture_buffer.sv
// Captures qualified I/Q samples into RAM under arm/stop control with
// one-shot, circular and skip-then-fill modes, plus peak/saturation stats.
module iq_capture_buffer
  import iq_capture_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 1024,
  parameter int SKIP_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic [SKIP_W-1:0]   skip_cnt,
  input  logic [DATA_W-1:0]   din_real,
  input  logic [DATA_W-1:0]   din_imag,
  input  logic                din_valid,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     wr_count,
  output logic                wrapped,
  output logic [ADDR_W-1:0]   oldest_addr,
  output logic [DATA_W-1:0]   peak_abs,
  output logic                sat_flag,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [2*DATA_W-1:0] rd_data,
  output logic                rd_valid
);

  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  cap_state_t          state, state_next;
  logic [1:0]          mode_q;
  logic [SKIP_W-1:0]   skip_left;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     count_q;
  logic                wrapped_q;
  logic [DATA_W-1:0]   peak_q;
  logic                sat_q;
  logic                start, skip_dec, do_write;
  logic [DATA_W-1:0]   abs_i, abs_q, sample_peak;
  logic                sample_sat;

  always_comb begin
    abs_i       = DATA_W'(sat_abs(32'(signed'(din_real)), DATA_W));
    abs_q       = DATA_W'(sat_abs(32'(signed'(din_imag)), DATA_W));
    sample_peak = (abs_i > abs_q) ? abs_i : abs_q;
    sample_sat  = (din_real == MIN_VAL) || (din_imag == MIN_VAL);
  end

  // stop is checked before the sample so a stop-cycle sample is dropped.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    skip_dec   = 1'b0;
    do_write   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          start      = 1'b1;
          state_next = (mode == MODE_SKIP && skip_cnt != '0) ? ST_SKIP : ST_CAPTURE;
        end
      end
      ST_SKIP: begin
        if (stop)
          state_next = ST_DONE;
        else if (din_valid) begin
          skip_dec = 1'b1;
          if (skip_left == SKIP_W'(1))
            state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (stop)
          state_next = ST_DONE;
        else if (din_valid) begin
          do_write = 1'b1;
          if (mode_q != MODE_CIRC && (&wr_ptr))
            state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= '0;
      skip_left <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      peak_q    <= '0;
      sat_q     <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      state    <= state_next;
      rd_valid <= rd_en;
      if (start) begin
        mode_q    <= mode;
        skip_left <= skip_cnt;
        wr_ptr    <= '0;
        count_q   <= '0;
        wrapped_q <= 1'b0;
        peak_q    <= '0;
        sat_q     <= 1'b0;
      end
      if (skip_dec)
        skip_left <= skip_left - SKIP_W'(1);
      if (do_write) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (count_q != (ADDR_W+1)'(DEPTH))
          count_q <= count_q + (ADDR_W+1)'(1);
        if (mode_q == MODE_CIRC && (&wr_ptr))
          wrapped_q <= 1'b1;
        if (sample_peak > peak_q)
          peak_q <= sample_peak;
        if (sample_sat)
          sat_q <= 1'b1;
      end
    end
  end

  iq_capture_ram #(
    .WIDTH(2*DATA_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (do_write),
    .wr_addr(wr_ptr),
    .wr_data({din_real, din_imag}),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign busy        = (state == ST_SKIP) || (state == ST_CAPTURE);
  assign done        = (state == ST_DONE);
  assign wr_count    = count_q;
  assign wrapped     = wrapped_q;
  assign oldest_addr = wrapped_q ? wr_ptr : '0;
  assign peak_abs    = peak_q;
  assign sat_flag    = sat_q;

endmodule

// File: tb/tb_iq_capture_buffer.sv
// Scoreboard bench for iq_capture_buffer: directed scenarios followed by
// randomized arm/stop/valid/read traffic against a sample-list reference model.
module tb_iq_capture_buffer;

  localparam int DATA_W = 18;
  localparam int DEPTH  = 16;
  localparam int SKIP_W = 16;
  localparam int ADDR_W = 4;
  localparam logic [DATA_W-1:0] MIN_VAL = 18'h20000;

  logic                clk = 1'b0;
  logic                rst, arm, stop, din_valid, rd_en;
  logic [1:0]          mode;
  logic [SKIP_W-1:0]   skip_cnt;
  logic [DATA_W-1:0]   din_real, din_imag;
  logic [ADDR_W-1:0]   rd_addr;
  logic                busy, done, wrapped, sat_flag, rd_valid;
  logic [ADDR_W:0]     wr_count;
  logic [ADDR_W-1:0]   oldest_addr;
  logic [DATA_W-1:0]   peak_abs;
  logic [2*DATA_W-1:0] rd_data;

  iq_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKIP_W(SKIP_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .mode(mode), .skip_cnt(skip_cnt),
    .din_real(din_real), .din_imag(din_imag), .din_valid(din_valid),
    .busy(busy), .done(done), .wr_count(wr_count), .wrapped(wrapped),
    .oldest_addr(oldest_addr), .peak_abs(peak_abs), .sat_flag(sat_flag),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                  care;
    logic [2*DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t             sb_q[$];
  int                  tests_run = 0;
  int                  tests_failed = 0;
  bit                  mon_on = 1'b0;

  // Reference model: phase 0 idle, 1 skipping, 2 capturing, 3 done.
  int                  m_phase = 0;
  int                  m_skip_left = 0;
  int                  m_mode = 0;
  logic [2*DATA_W-1:0] m_captured[$];
  logic [2*DATA_W-1:0] m_mem[DEPTH];
  bit                  m_written[DEPTH];
  bit                  exp_rd_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_abs(input logic [DATA_W-1:0] x);
    int v;
    v = int'($signed(x));
    if (v == -131072) return 131071;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int exp_count();
    return (m_captured.size() > DEPTH) ? DEPTH : m_captured.size();
  endfunction

  function automatic bit exp_wrapped();
    return (m_mode == 1) && (m_captured.size() >= DEPTH);
  endfunction

  function automatic int exp_oldest();
    return exp_wrapped() ? (m_captured.size() % DEPTH) : 0;
  endfunction

  function automatic int exp_peak();
    int p = 0;
    foreach (m_captured[k]) begin
      if (model_abs(m_captured[k][35:18]) > p) p = model_abs(m_captured[k][35:18]);
      if (model_abs(m_captured[k][17:0]) > p)  p = model_abs(m_captured[k][17:0]);
    end
    return p;
  endfunction

  function automatic bit exp_sat();
    foreach (m_captured[k])
      if (m_captured[k][35:18] == MIN_VAL || m_captured[k][17:0] == MIN_VAL) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DATA_W-1:0] rand_sample();
    if ($urandom_range(0, 9) == 0) return MIN_VAL;
    return DATA_W'($urandom);
  endfunction

  // Drive one cycle of inputs, let the edge pass, then advance the model.
  task automatic applyStimulus(input bit a, input bit s, input bit v,
                               input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                               input bit r, input int ra);
    rd_exp_t e;
    arm = a; stop = s; din_valid = v; din_real = re; din_imag = im;
    rd_en = r; rd_addr = ADDR_W'(ra);
    @(posedge clk);
    #1;
    exp_rd_valid = !rst && r;
    if (rst) begin
      m_phase = 0; m_mode = 0; m_skip_left = 0;
      m_captured.delete();
      foreach (m_written[k]) m_written[k] = 1'b0;
    end else begin
      if (r) begin
        e.care = m_written[ra];
        e.data = m_mem[ra];
        sb_q.push_back(e);
      end
      if ((m_phase == 1 || m_phase == 2) && s)
        m_phase = 3;
      else if ((m_phase == 0 || m_phase == 3) && a) begin
        m_captured.delete();
        m_mode = mode;
        m_skip_left = skip_cnt;
        m_phase = (mode == 2 && skip_cnt != 0) ? 1 : 2;
      end else if (m_phase == 1 && v) begin
        m_skip_left--;
        if (m_skip_left == 0) m_phase = 2;
      end else if (m_phase == 2 && v) begin
        m_mem[m_captured.size() % DEPTH] = {re, im};
        m_written[m_captured.size() % DEPTH] = 1'b1;
        m_captured.push_back({re, im});
        if (m_mode != 1 && m_captured.size() == DEPTH) m_phase = 3;
      end
    end
    arm = 0; stop = 0; din_valid = 0; rd_en = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, '0, '0, 0, 0);
    rst = 1'b0;
  endtask

  // Monitor: status against the model every cycle, read data from the queue.
  always @(negedge clk) begin
    if (mon_on) begin
      checkOutput("busy", busy, (m_phase == 1 || m_phase == 2));
      checkOutput("done", done, (m_phase == 3));
      checkOutput("wr_count", wr_count, exp_count());
      checkOutput("wrapped", wrapped, exp_wrapped());
      checkOutput("oldest_addr", oldest_addr, exp_oldest());
      checkOutput("peak_abs", peak_abs, exp_peak());
      checkOutput("sat_flag", sat_flag, exp_sat());
      checkOutput("rd_valid", rd_valid, exp_rd_valid);
      if (rd_valid) begin
        if (sb_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL rd_unexpected: got rd_valid with no pending read, required none");
        end else begin
          rd_exp_t e;
          e = sb_q.pop_front();
          if (e.care) checkOutput("rd_data", rd_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [2*DATA_W-1:0] ev;
    rst = 1'b1; arm = 0; stop = 0; din_valid = 0; rd_en = 0;
    mode = 2'd0; skip_cnt = '0; din_real = '0; din_imag = '0; rd_addr = '0;
    applyStimulus(0, 0, 0, '0, '0, 0, 0);
    applyStimulus(0, 0, 0, '0, '0, 0, 0);
    rst = 1'b0;
    mon_on = 1'b1;
    checkOutput("reset_wr_count", wr_count, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rd_data", rd_data, 0);

    // One-shot ramp: 17 samples offered, only 16 stored.
    mode = 2'd0;
    applyStimulus(1, 0, 0, '0, '0, 0, 0);
    for (int n = 0; n < 17; n++) applyStimulus(0, 0, 1, 18'(n), 18'(-n), 0, 0);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_count", wr_count, 16);
    applyStimulus(0, 0, 0, '0, '0, 1, 5);
    ev = {18'd5, 18'h3FFFB};
    checkOutput("t1_rd5", rd_data, ev);
    applyStimulus(0, 0, 0, '0, '0, 1, 0);
    checkOutput("t1_rd0", rd_data, 0);

    // Circular: 20 samples then stop.
    mode = 2'd1;
    applyStimulus(1, 0, 0, '0, '0, 0, 0);
    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 1, 18'(1000 + k), 18'(k), 0, 0);
    applyStimulus(0, 1, 1, 18'd7, 18'd7, 0, 0);
    checkOutput("t2_wrapped", wrapped, 1);
    checkOutput("t2_count", wr_count, 16);
    checkOutput("t2_oldest", oldest_addr, 4);
    applyStimulus(0, 0, 0, '0, '0, 1, 3);
    ev = {18'd1019, 18'd19};
    checkOutput("t2_rd3", rd_data, ev);

    // Skip-then-fill with gapped valid.
    mode = 2'd2; skip_cnt = 16'd3;
    applyStimulus(1, 0, 0, '0, '0, 0, 0);
    checkOutput("t3_busy_skip", busy, 1);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(0, 0, 1, 18'(10 * k), 18'(k), 0, 0);
      if (k == 2) checkOutput("t3_count_skip", wr_count, 0);
      applyStimulus(0, 0, 0, '0, '0, 0, 0);
    end
    applyStimulus(0, 1, 0, '0, '0, 0, 0);
    applyStimulus(0, 0, 0, '0, '0, 1, 0);
    ev = {18'd40, 18'd4};
    checkOutput("t3_first", rd_data, ev);

    // Saturation and peak, cleared by re-arm.
    mode = 2'd0; skip_cnt = '0;
    applyStimulus(1, 0, 0, '0, '0, 0, 0);
    applyStimulus(0, 0, 1, MIN_VAL, 18'd0, 0, 0);
    applyStimulus(0, 0, 1, 18'd0, 18'd100, 0, 0);
    checkOutput("t4_peak", peak_abs, 131071);
    checkOutput("t4_sat", sat_flag, 1);
    applyStimulus(0, 1, 0, '0, '0, 0, 0);
    applyStimulus(1, 0, 0, '0, '0, 0, 0);
    checkOutput("t4_peak_clr", peak_abs, 0);
    checkOutput("t4_sat_clr", sat_flag, 0);

    // arm+stop collisions.
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 1, 18'(k), 18'(k), 0, 0);
    applyStimulus(1, 1, 1, 18'd99, 18'd99, 0, 0);
    checkOutput("t5_done", done, 1);
    checkOutput("t5_frozen", wr_count, 5);
    pulse_reset();
    applyStimulus(1, 1, 0, '0, '0, 0, 0);
    checkOutput("t5_idle_arm", busy, 1);

    // Reset mid-capture.
    pulse_reset();
    applyStimulus(1, 0, 0, '0, '0, 0, 0);
    for (int k = 0; k < 7; k++) applyStimulus(0, 0, 1, 18'(k), 18'(k), 0, 0);
    checkOutput("t6_pre", wr_count, 7);
    pulse_reset();
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_done", done, 0);
    checkOutput("t6_count", wr_count, 0);
    applyStimulus(1, 0, 0, '0, '0, 0, 0);
    applyStimulus(0, 0, 1, 18'd321, 18'd123, 0, 0);
    applyStimulus(0, 0, 0, '0, '0, 1, 0);
    ev = {18'd321, 18'd123};
    checkOutput("t6_addr0", rd_data, ev);

    // Randomized traffic.
    for (int r = 0; r < 12; r++) begin
      mode = 2'($urandom_range(0, 3));
      skip_cnt = SKIP_W'($urandom_range(0, 4));
      applyStimulus(1, 0, bit'($urandom_range(0, 1)), rand_sample(), rand_sample(), 0, 0);
      for (int c = 0; c < 45; c++) begin
        if ($urandom_range(0, 99) == 0) rst = 1'b1;
        applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 3) != 0, rand_sample(), rand_sample(),
                      $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1));
        rst = 1'b0;
      end
    end

    idle(3);
    checkOutput("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
